// File: rtl/uart_txd.sv
// ---------------------------------------------------------------------------
// uart_txd
// UART transmitter running on the receiver's oversampling clock. One byte per
// accepted request is serialised as: start bit, 8 data bits LSB-first,
// optional parity bit, one stop bit. Each bit lasts OVERSAMPLE clock cycles.
// All outputs come straight from flops; there is no input-to-output path.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_txd #(
    parameter int OVERSAMPLE = 16              // sample_clk cycles per bit, 2..256
) (
    input  logic       sample_clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] tx_data,
    input  logic       parity_en,
    input  logic       parity_kind,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam int              CW        = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]   SAMP_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state_q;
    state_t          state_nxt;

    logic [CW-1:0]   samp_cnt;
    logic [CW-1:0]   samp_cnt_nxt;
    logic [2:0]      bit_cnt;
    logic [2:0]      bit_cnt_nxt;
    logic [7:0]      shreg;
    logic [7:0]      shreg_nxt;
    logic            par_bit;
    logic            par_bit_nxt;
    logic            par_en_q;
    logic            par_en_nxt;

    logic            txd_q;
    logic            txd_nxt;
    logic            busy_q;
    logic            busy_nxt;
    logic            done_q;
    logic            done_nxt;

    // Last sample_clk cycle of the current serial bit.
    logic            bit_end;
    assign bit_end = (samp_cnt == SAMP_LAST);

    // State register: abandons any frame in progress on reset.
    always_ff @(posedge sample_clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic: advance only at bit boundaries (or on acceptance in IDLE).
    always_comb begin
        // NOTE: default assignment first, so no path leaves state_nxt unassigned and no latch is inferred.
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (send) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_cnt == 3'd7)) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output/datapath logic: next values of the counters, shifter and registered pins.
    always_comb begin
        samp_cnt_nxt = samp_cnt;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        par_bit_nxt  = par_bit;
        par_en_nxt   = par_en_q;
        txd_nxt      = txd_q;
        busy_nxt     = busy_q;
        done_nxt     = 1'b0;

        // Every non-idle state times its bit with the same wrap-around counter.
        if (state_q != IDLE) begin
            samp_cnt_nxt = bit_end ? '0 : samp_cnt + CW'(1);
        end

        case (state_q)
            IDLE: begin
                samp_cnt_nxt = '0;
                txd_nxt      = 1'b1;
                busy_nxt     = 1'b0;
                if (send) begin
                    // Everything the frame needs is captured here; later input changes are ignored.
                    shreg_nxt    = tx_data;
                    par_en_nxt   = parity_en;
                    par_bit_nxt  = (^tx_data) ^ parity_kind;
                    bit_cnt_nxt  = 3'd0;
                    busy_nxt     = 1'b1;
                    txd_nxt      = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    txd_nxt = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_nxt   = {1'b0, shreg[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        txd_nxt = par_en_q ? par_bit : 1'b1;
                    end else begin
                        // shreg[1] becomes shreg[0] after this shift.
                        txd_nxt = shreg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    txd_nxt = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    busy_nxt = 1'b0;
                    done_nxt = 1'b1;
                end
            end
            default: begin
                txd_nxt  = 1'b1;
                busy_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; the line returns high at once on reset.
    always_ff @(posedge sample_clk or posedge rst) begin
        if (rst) begin
            samp_cnt <= '0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            par_bit  <= 1'b0;
            par_en_q <= 1'b0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            samp_cnt <= samp_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            par_bit  <= par_bit_nxt;
            par_en_q <= par_en_nxt;
            txd_q    <= txd_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_txd.sv
// ---------------------------------------------------------------------------
// tb_uart_txd
// Drives uart_txd with directed and random requests and compares the sampled
// txd/busy/done traces with a frame-level reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_txd;

    localparam int OS   = 16;
    localparam int MAXC = 336;   // longest trace kept per comparison

    logic       sample_clk = 1'b0;
    logic       rst;
    logic       send;
    logic [7:0] tx_data;
    logic       parity_en;
    logic       parity_kind;
    logic       txd;
    logic       busy;
    logic       done;

    int checks = 0;
    int passes = 0;

    // Expected and observed per-cycle traces.
    logic exp_t[$];
    logic exp_b[$];
    logic exp_d[$];
    logic obs_t[$];
    logic obs_b[$];
    logic obs_d[$];

    uart_txd #(.OVERSAMPLE(OS)) dut (
        .sample_clk  (sample_clk),
        .rst         (rst),
        .send        (send),
        .tx_data     (tx_data),
        .parity_en   (parity_en),
        .parity_kind (parity_kind),
        .txd         (txd),
        .busy        (busy),
        .done        (done)
    );

    always #5 sample_clk = ~sample_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------

    // Parity bit chosen so that data ones + parity is odd (odd=1) or even (odd=0).
    function automatic logic model_parity(input logic [7:0] d, input logic odd);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        if (odd) return (ones % 2 == 0);
        return (ones % 2 == 1);
    endfunction

    task automatic model_frame(input logic [7:0] d, input logic pen, input logic odd);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(model_parity(d, odd));
        bits.push_back(1'b1);
        foreach (bits[k]) begin
            repeat (OS) begin
                exp_t.push_back(bits[k]);
                exp_b.push_back(1'b1);
                exp_d.push_back(1'b0);
            end
        end
    endtask

    task automatic model_done();
        exp_t.push_back(1'b1);
        exp_b.push_back(1'b0);
        exp_d.push_back(1'b1);
    endtask

    task automatic model_idle(input int n);
        repeat (n) begin
            exp_t.push_back(1'b1);
            exp_b.push_back(1'b0);
            exp_d.push_back(1'b0);
        end
    endtask

    task automatic clear_traces();
        exp_t.delete(); exp_b.delete(); exp_d.delete();
        obs_t.delete(); obs_b.delete(); obs_d.delete();
    endtask

    function automatic logic [MAXC-1:0] pack(input logic q[$]);
        logic [MAXC-1:0] v;
        v = '0;
        for (int i = 0; i < q.size() && i < MAXC; i++) v[i] = q[i];
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------

    task automatic sample_cycle();
        @(negedge sample_clk);
        obs_t.push_back(txd);
        obs_b.push_back(busy);
        obs_d.push_back(done);
    endtask

    task automatic kick(input logic [7:0] d, input logic pen, input logic odd);
        send        = 1'b1;
        tx_data     = d;
        parity_en   = pen;
        parity_kind = odd;
    endtask

    // Sample ncyc cycles. Cycle c's inputs are set for the edge ending cycle c:
    // send held with hold_data while c < hold_until, otherwise send only at
    // cycles pa/pb (with 0xFF) and random junk on the other inputs.
    task automatic run_trace(input int ncyc, input int hold_until, input logic [7:0] hold_data,
                             input int pa, input int pb);
        for (int c = 0; c < ncyc; c++) begin
            sample_cycle();
            if (c < hold_until) begin
                send        = 1'b1;
                tx_data     = hold_data;
                parity_en   = 1'b0;
                parity_kind = 1'b0;
            end else begin
                send        = (c == pa) || (c == pb);
                tx_data     = send ? 8'hFF : 8'($urandom);
                parity_en   = 1'($urandom);
                parity_kind = 1'($urandom);
            end
        end
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        rst = 1'b1; send = 1'b1; tx_data = 8'hA5; parity_en = 1'b0; parity_kind = 1'b0;
        repeat (3) @(negedge sample_clk);
        checks++;
        if ({txd, busy, done} !== 3'b100)
            $display("FAIL reset_outputs: txd/busy/done got %b expected 100", {txd, busy, done});
        else passes++;
        rst = 1'b0; send = 1'b0;
        repeat (2) @(negedge sample_clk);
        checks++;
        if ({txd, busy, done} !== 3'b100)
            $display("FAIL idle_after_reset: txd/busy/done got %b expected 100", {txd, busy, done});
        else passes++;
    endtask

    task automatic test_a5_no_parity();
        logic [9:0] mid;
        int nbusy;
        clear_traces();
        kick(8'hA5, 1'b0, 1'b0);
        model_frame(8'hA5, 1'b0, 1'b0); model_done(); model_idle(1);
        run_trace(exp_t.size(), 0, 8'h00, -1, -1);
        checks++;
        if (pack(obs_t) !== pack(exp_t))
            $display("FAIL a5_txd: got %h expected %h", pack(obs_t), pack(exp_t));
        else passes++;
        checks++;
        if ({pack(obs_b), pack(obs_d)} !== {pack(exp_b), pack(exp_d)})
            $display("FAIL a5_busy_done: busy got %h expected %h done got %h expected %h",
                     pack(obs_b), pack(exp_b), pack(obs_d), pack(exp_d));
        else passes++;
        // Mid-bit line levels: 0,1,0,1,0,0,1,0,1,1 (index 0 = start bit).
        for (int k = 0; k < 10; k++) mid[k] = obs_t[8 + OS * k];
        checks++;
        if (mid !== 10'b11_0100_1010)
            $display("FAIL a5_bit_levels: got %b expected %b", mid, 10'b11_0100_1010);
        else passes++;
        nbusy = 0;
        foreach (obs_b[i]) nbusy += int'(obs_b[i]);
        checks++;
        if (nbusy !== 160)
            $display("FAIL a5_busy_cycles: got %0d expected 160", nbusy);
        else passes++;
    endtask

    task automatic test_odd_parity();
        int nbusy;
        clear_traces();
        kick(8'h55, 1'b1, 1'b1);
        model_frame(8'h55, 1'b1, 1'b1); model_done(); model_idle(1);
        run_trace(exp_t.size(), 0, 8'h00, -1, -1);
        checks++;
        if (pack(obs_t) !== pack(exp_t))
            $display("FAIL odd_parity_txd: got %h expected %h", pack(obs_t), pack(exp_t));
        else passes++;
        checks++;
        if (obs_t[9 * OS + 8] !== 1'b1)
            $display("FAIL odd_parity_bit: got %b expected 1", obs_t[9 * OS + 8]);
        else passes++;
        nbusy = 0;
        foreach (obs_b[i]) nbusy += int'(obs_b[i]);
        checks++;
        if (nbusy !== 176 || obs_d[176] !== 1'b1)
            $display("FAIL odd_parity_length: busy cycles %0d done@176 %b expected 176 and 1", nbusy, obs_d[176]);
        else passes++;
    endtask

    task automatic test_even_parity();
        logic [7:0] vals[2] = '{8'h07, 8'h03};
        logic       pbit[2] = '{1'b1, 1'b0};
        for (int n = 0; n < 2; n++) begin
            clear_traces();
            kick(vals[n], 1'b1, 1'b0);
            model_frame(vals[n], 1'b1, 1'b0); model_done(); model_idle(1);
            run_trace(exp_t.size(), 0, 8'h00, -1, -1);
            checks++;
            if (pack(obs_t) !== pack(exp_t))
                $display("FAIL even_parity_txd_%h: got %h expected %h", vals[n], pack(obs_t), pack(exp_t));
            else passes++;
            checks++;
            if (obs_t[9 * OS + 8] !== pbit[n])
                $display("FAIL even_parity_bit_%h: got %b expected %b", vals[n], obs_t[9 * OS + 8], pbit[n]);
            else passes++;
        end
    endtask

    task automatic test_ignored_requests();
        clear_traces();
        kick(8'h00, 1'b0, 1'b0);
        model_frame(8'h00, 1'b0, 1'b0); model_done(); model_idle(1);
        run_trace(exp_t.size(), 0, 8'h00, 20, 159);
        checks++;
        if (pack(obs_t) !== pack(exp_t))
            $display("FAIL ignored_txd: got %h expected %h", pack(obs_t), pack(exp_t));
        else passes++;
        checks++;
        if ({pack(obs_b), pack(obs_d)} !== {pack(exp_b), pack(exp_d)})
            $display("FAIL ignored_busy_done: busy got %h expected %h done got %h expected %h",
                     pack(obs_b), pack(exp_b), pack(obs_d), pack(exp_d));
        else passes++;
    endtask

    task automatic test_reset_mid_frame();
        int ndone;
        clear_traces();
        kick(8'hC3, 1'b0, 1'b0);
        model_frame(8'hC3, 1'b0, 1'b0);
        while (exp_t.size() > 70) begin
            void'(exp_t.pop_back()); void'(exp_b.pop_back()); void'(exp_d.pop_back());
        end
        run_trace(70, 0, 8'h00, -1, -1);
        checks++;
        if (pack(obs_t) !== pack(exp_t) || pack(obs_b) !== pack(exp_b))
            $display("FAIL abort_prefix: txd got %h expected %h", pack(obs_t), pack(exp_t));
        else passes++;
        // Cycle 70 begins at the next rising edge; hit reset inside it.
        @(posedge sample_clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({txd, busy, done} !== 3'b100)
            $display("FAIL abort_immediate: txd/busy/done got %b expected 100", {txd, busy, done});
        else passes++;
        ndone = 0;
        repeat (3) begin
            @(negedge sample_clk);
            ndone += int'(done);
        end
        rst = 1'b0;
        clear_traces();
        kick(8'h3C, 1'b0, 1'b0);
        model_frame(8'h3C, 1'b0, 1'b0); model_done(); model_idle(1);
        run_trace(exp_t.size(), 0, 8'h00, -1, -1);
        foreach (obs_d[i]) if (i < 160) ndone += int'(obs_d[i]);
        checks++;
        if (ndone !== 0)
            $display("FAIL abort_no_done: done pulses got %0d expected 0", ndone);
        else passes++;
        checks++;
        if (pack(obs_t) !== pack(exp_t))
            $display("FAIL after_abort_txd: got %h expected %h", pack(obs_t), pack(exp_t));
        else passes++;
        checks++;
        if ({pack(obs_b), pack(obs_d)} !== {pack(exp_b), pack(exp_d)})
            $display("FAIL after_abort_busy_done: busy got %h expected %h done got %h expected %h",
                     pack(obs_b), pack(exp_b), pack(obs_d), pack(exp_d));
        else passes++;
    endtask

    task automatic test_back_to_back();
        int idx[$];
        clear_traces();
        kick(8'h12, 1'b0, 1'b0);
        model_frame(8'h12, 1'b0, 1'b0); model_done();
        model_frame(8'h34, 1'b0, 1'b0); model_done(); model_idle(1);
        // Hold send through the second done cycle's preceding edge only.
        run_trace(exp_t.size(), 321, 8'h34, -1, -1);
        checks++;
        if (pack(obs_t) !== pack(exp_t))
            $display("FAIL b2b_txd: got %h expected %h", pack(obs_t), pack(exp_t));
        else passes++;
        checks++;
        if ({pack(obs_b), pack(obs_d)} !== {pack(exp_b), pack(exp_d)})
            $display("FAIL b2b_busy_done: busy got %h expected %h done got %h expected %h",
                     pack(obs_b), pack(exp_b), pack(obs_d), pack(exp_d));
        else passes++;
        foreach (obs_d[i]) if (obs_d[i] === 1'b1) idx.push_back(i);
        checks++;
        if (idx.size() !== 2 || (idx[1] - idx[0]) !== 161)
            $display("FAIL b2b_done_spacing: %0d pulses first %0d last %0d expected 2 pulses 161 apart",
                     idx.size(), (idx.size() > 0) ? idx[0] : -1, (idx.size() > 0) ? idx[idx.size()-1] : -1);
        else passes++;
    endtask

    task automatic test_random_frames();
        logic [7:0] d;
        logic       pen;
        logic       odd;
        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge sample_clk);
            d   = 8'($urandom);
            pen = 1'($urandom);
            odd = 1'($urandom);
            clear_traces();
            kick(d, pen, odd);
            model_frame(d, pen, odd); model_done(); model_idle(1);
            run_trace(exp_t.size(), 0, 8'h00, -1, -1);
            checks++;
            if (pack(obs_t) !== pack(exp_t))
                $display("FAIL random_%0d_txd (data %h pen %b odd %b): got %h expected %h",
                         n, d, pen, odd, pack(obs_t), pack(exp_t));
            else passes++;
            checks++;
            if ({pack(obs_b), pack(obs_d)} !== {pack(exp_b), pack(exp_d)})
                $display("FAIL random_%0d_busy_done: busy got %h expected %h done got %h expected %h",
                         n, pack(obs_b), pack(exp_b), pack(obs_d), pack(exp_d));
            else passes++;
        end
    endtask

    initial begin
        rst = 1'b1; send = 1'b0; tx_data = 8'h00; parity_en = 1'b0; parity_kind = 1'b0;
        test_reset();
        test_a5_no_parity();
        test_odd_parity();
        test_even_parity();
        test_ignored_requests();
        test_reset_mid_frame();
        test_back_to_back();
        test_random_frames();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
